pipe_hazard_ctrl: RTL



---
 rtl/pipe_hazard_ctrl_pkg.sv | 19 +
 rtl/pipe_hazard_ctrl_if.sv | 48 ++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: controller state encodings,
// register-index type and the NOP word the pipeline latches load on flush/bubble.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 3;

    // addi x0,x0,0 -- loaded into F/D or D/X together with instrValid=0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD_USE = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALTED   = 2'd3
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/EX hazard fields and memory/halt status
// flowing in, latch hold/flush/bubble controls and status flowing out.
interface pipe_hazard_ctrl_if
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             instrValidD;
    reg_idx_t         rsD;
    reg_idx_t         rtD;
    logic             useRsD;
    logic             useRtD;
    logic             memReadX;
    logic             regWriteX;
    reg_idx_t         writeRegX;
    logic             pcRedirectX;
    logic             imemStall;
    logic             dmemStall;
    logic             haltW;

    logic             stallF;
    logic             stallD;
    logic             flushD;
    logic             bubbleX;
    logic             freezeAll;
    logic             halted;
    logic             errDmem;
    logic [CNT_W-1:0] stallCount;

    // Pipeline side: supplies hazard information, consumes the controls
    modport master (
        output instrValidD, rsD, rtD, useRsD, useRtD,
               memReadX, regWriteX, writeRegX,
               pcRedirectX, imemStall, dmemStall, haltW,
        input  stallF, stallD, flushD, bubbleX, freezeAll,
               halted, errDmem, stallCount
    );

    // Controller side
    modport slave (
        input  instrValidD, rsD, rtD, useRsD, useRtD,
               memReadX, regWriteX, writeRegX,
               pcRedirectX, imemStall, dmemStall, haltW,
        output stallF, stallD, flushD, bubbleX, freezeAll,
               halted, errDmem, stallCount
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use detector: a load in EX whose destination is read by the valid
// instruction in decode. Purely combinational.
module load_use_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic     instr_valid_d,
    input  reg_idx_t rs_d,
    input  reg_idx_t rt_d,
    input  logic     use_rs_d,
    input  logic     use_rt_d,
    input  logic     mem_read_x,
    input  logic     reg_write_x,
    input  reg_idx_t write_reg_x,
    output logic     load_use
);

    reg_idx_t src_idx [2];
    logic     src_use [2];
    logic     src_hit [2];

    assign src_idx[0] = rs_d;
    assign src_idx[1] = rt_d;
    assign src_use[0] = use_rs_d;
    assign src_use[1] = use_rt_d;

    // One comparator per decode source operand
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_use[gi] && (src_idx[gi] == write_reg_x);
        end
    endgenerate

    assign load_use = mem_read_x && reg_write_x && instr_valid_d &&
                      (src_hit[0] || src_hit[1]);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline. Resolves dmem wait,
// branch redirect, load-use, imem wait and halt into one control set per cycle,
// counts stalled fetch cycles and flags data-memory timeouts.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DMEM_TIMEOUT = 255
)(
    input  logic clk,
    input  logic rst,
    pipe_hazard_ctrl_if.slave bus
);

    // Wait counter must reach DMEM_TIMEOUT+1 so the overrun is observable
    localparam int                WAIT_W     = $clog2(DMEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(DMEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = WAIT_W'(DMEM_TIMEOUT + 1);

    hz_state_e         state_reg, state_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              err_reg, err_next;
    logic [CNT_W-1:0]  stall_cnt_reg, stall_cnt_next;

    logic load_use;
    logic stall_f, stall_d, flush_d, bubble_x, freeze_all, halted;

    load_use_detect u_load_use_detect (
        .instr_valid_d (bus.instrValidD),
        .rs_d          (bus.rsD),
        .rt_d          (bus.rtD),
        .use_rs_d      (bus.useRsD),
        .use_rt_d      (bus.useRtD),
        .mem_read_x    (bus.memReadX),
        .reg_write_x   (bus.regWriteX),
        .write_reg_x   (bus.writeRegX),
        .load_use      (load_use)
    );

    // State and counter registers; reset returns to RUN with clean counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            wait_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            err_reg       <= err_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    // Priority arbitration of hazards into controls and next state
    always_comb begin
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        flush_d       = 1'b0;
        bubble_x      = 1'b0;
        freeze_all    = 1'b0;
        halted        = 1'b0;
        state_next    = ST_RUN;
        wait_cnt_next = '0;

        if (state_reg == ST_HALTED) begin
            halted        = 1'b1;
            freeze_all    = 1'b1;
            stall_f       = 1'b1;
            stall_d       = 1'b1;
            state_next    = ST_HALTED;
            wait_cnt_next = wait_cnt_reg;
        end else if (bus.dmemStall) begin
            freeze_all    = 1'b1;
            stall_f       = 1'b1;
            stall_d       = 1'b1;
            state_next    = ST_MEM_WAIT;
            wait_cnt_next = (wait_cnt_reg == WAIT_MAX) ? wait_cnt_reg
                                                       : wait_cnt_reg + 1'b1;
        end else if (bus.pcRedirectX) begin
            flush_d  = 1'b1;
            bubble_x = 1'b1;
        end else if (load_use && (state_reg != ST_LOAD_USE)) begin
            // Only one bubble per load: the hazard is masked in LOAD_USE
            stall_f    = 1'b1;
            stall_d    = 1'b1;
            bubble_x   = 1'b1;
            state_next = ST_LOAD_USE;
        end else if (bus.imemStall) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end

        // Halt overrides the next state chosen above, not this cycle's controls
        if (bus.haltW) begin
            state_next = ST_HALTED;
        end
    end

    // Sticky timeout flag and saturating stall-cycle counter
    always_comb begin
        err_next       = err_reg || (wait_cnt_next > WAIT_LIMIT);
        stall_cnt_next = stall_cnt_reg;
        if (stall_f && (state_reg != ST_HALTED) && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    assign bus.stallF     = stall_f;
    assign bus.stallD     = stall_d;
    assign bus.flushD     = flush_d;
    assign bus.bubbleX    = bubble_x;
    assign bus.freezeAll  = freeze_all;
    assign bus.halted     = halted;
    assign bus.errDmem    = err_reg;
    assign bus.stallCount = stall_cnt_reg;

endmodule
